// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the HI/LO register pair.
//   Executes MULTU/MULT (shift-add radix-2) and DIVU/DIV (restoring) over
//   WIDTH cycles, accepts MTHI/MTLO writes while idle, exposes HI/LO.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        request new operation (sampled in IDLE only)
//   op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b         multiplicand/dividend, multiplier/divisor
//   wr_hi/wr_lo  MTHI/MTLO write strobes (IDLE only), data on wdata
//   busy         operation in progress
//   done         one-cycle pulse, HI/LO hold the new result
//   div_by_zero  one-cycle pulse with done for a divide by zero
//   hi, lo       HI/LO registers
// Optional feature: define MULDIV_EARLY_OUT_EN to end multiplies as soon as
// the remaining multiplier magnitude is zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DZ} state_t;
  state_t state, state_n;

  logic               is_div_q;
  logic               neg_q;     // quotient / product negative
  logic               rneg_q;    // remainder takes dividend sign
  logic [WIDTH-1:0]   a_raw_q;
  logic [WIDTH-1:0]   mp_q;      // remaining multiplier bits
  logic [WIDTH-1:0]   dvsr_q;
  logic [WIDTH-1:0]   quo_q;     // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   rem_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mc_q;      // multiplicand aligned to current bit
  logic [CW-1:0]      cnt_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] acc_n, prod_s;
  logic [WIDTH-1:0]   mp_n, quo_n, rem_n, quo_s, rem_s;
  logic [WIDTH:0]     rem_sh, trial;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               last;

  always_comb begin
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    a_abs = a_neg ? -a : a;
    b_abs = b_neg ? -b : b;
  end

  // One iteration of each algorithm; the active one is selected by is_div_q.
  always_comb begin
    acc_n  = mp_q[0] ? acc_q + mc_q : acc_q;
    mp_n   = mp_q >> 1;
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvsr_q};
    if (!trial[WIDTH]) begin
      rem_n = trial[WIDTH-1:0];
      quo_n = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = rem_sh[WIDTH-1:0];
      quo_n = {quo_q[WIDTH-2:0], 1'b0};
    end
    prod_s = neg_q  ? -acc_n : acc_n;
    quo_s  = neg_q  ? -quo_n : quo_n;
    rem_s  = rneg_q ? -rem_n : rem_n;
    res_hi = is_div_q ? rem_s : prod_s[2*WIDTH-1:WIDTH];
    res_lo = is_div_q ? quo_s : prod_s[WIDTH-1:0];
`ifdef MULDIV_EARLY_OUT_EN
    // Multiply is complete once every set multiplier bit has been consumed.
    last = (cnt_q == CW'(1)) || (!is_div_q && mp_n == '0);
`else
    last = (cnt_q == CW'(1));
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = (state != IDLE);
    case (state)
      IDLE: if (start) state_n = (op[1] && b == '0) ? DZ : RUN;
      RUN:  if (last)  state_n = IDLE;
      DZ:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_div_q    <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      a_raw_q     <= '0;
      mp_q        <= '0;
      dvsr_q      <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      mc_q        <= '0;
      cnt_q       <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div_q <= op[1];
            neg_q    <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            a_raw_q  <= a;
            mp_q     <= b_abs;
            dvsr_q   <= b_abs;
            quo_q    <= a_abs;
            rem_q    <= '0;
            acc_q    <= '0;
            mc_q     <= {{WIDTH{1'b0}}, a_abs};
            cnt_q    <= CW'(WIDTH);
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        RUN: begin
          acc_q <= acc_n;
          mp_q  <= mp_n;
          mc_q  <= mc_q << 1;
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q - CW'(1);
          if (last) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        DZ: begin
          hi          <= a_raw_q;
          lo          <= '1;
          done        <= 1'b1;
          div_by_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS single-cycle core.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, and accepts MTHI/MTLO writes.
- Exposes HI/LO to the datapath for MFHI/MFLO read-back.
- Sits beside the ALU: operands come from the register-file read ports (srca/srcb); control decode drives start/op/wr_*.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- start, input, 1, request new operation; sampled in IDLE only.
- op, input, 2, 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a, input, WIDTH, multiplicand / dividend (rs).
- b, input, WIDTH, multiplier / divisor (rt).
- wr_hi, input, 1, MTHI write strobe.
- wr_lo, input, 1, MTLO write strobe.
- wdata, input, WIDTH, MTHI/MTLO data.
- busy, output, 1, operation in progress.
- done, output, 1, one-cycle pulse; HI/LO hold the new result.
- div_by_zero, output, 1, one-cycle pulse coincident with done for a divide with b==0.
- hi, output, WIDTH, HI register.
- lo, output, WIDTH, LO register.

Behaviour:
- Reset (async, level):
  - State goes to IDLE.
  - hi, lo, internal accumulators and counter are cleared to 0.
  - busy, done and div_by_zero go to 0.
  - Reset mid-operation aborts the operation; no result is written.
- States: IDLE, RUN, DZ.
- IDLE, start=1 at edge T0:
  - Latch op, a and b.
  - Signed ops: record the result signs and latch |a|, |b|.
  - Load the counter with WIDTH.
  - Divide with b==0: go to DZ. Otherwise go to RUN.
  - busy=1 from T0 onward.
- RUN:
  - One iteration per edge; counter decrements.
  - Multiply: shift-add radix-2 on a 2*WIDTH product register.
  - Divide: restoring; remainder and quotient shift.
  - At edge T0+WIDTH (counter 1->0), sign correction is applied combinationally and written to hi/lo. State returns to IDLE, busy=0, and done=1 for the following cycle.
  - Latency: WIDTH cycles from the start edge to the result edge.
- Multiply results:
  - hi:lo = full 2*WIDTH product.
  - Signed product is the two's complement of the magnitude product when the operand signs differ.
- Divide results:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no flag).
- DZ:
  - At edge T0+1: lo=all ones, hi=a (original value).
  - State returns to IDLE; done=1 and div_by_zero=1 for one cycle.
- start while busy: ignored. The operation in flight is unaffected.
- wr_hi/wr_lo:
  - Take effect at the edge in IDLE only; ignored while busy.
  - Both may be set in the same cycle.
  - start together with wr_* in IDLE: start wins and the writes are dropped.
- done is not a request. No acknowledge is required and it never stays high for more than one cycle.
- Back-to-back: start may be asserted in the cycle done is high (state is IDLE).
- hi/lo change only on a result edge, an accepted wr_* edge, or reset.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - MULT/MULTU terminate once the remaining (shifted) multiplier magnitude is zero.
  - Iterations = max(1, bit-length of |b|). Example: b=5 takes 3 cycles.
  - Divide latency is unchanged.
  - done/busy timing follows the actual termination edge.
- Undefined: every multiply takes exactly WIDTH cycles.

Test Plan:
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE; busy high 32 cycles; done pulses once after the 32nd edge.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Repeat with MULDIV_EARLY_OUT_EN -> same result, done after 3 cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=100, b=0 -> done and div_by_zero both high one cycle after start; lo=0xFFFFFFFF, hi=100.
- Start DIVU, assert start (MULTU) and wr_lo=1 (wdata=0x1234) at cycle 5 -> both ignored; DIVU result correct. Then wr_lo in IDLE -> lo=0x1234, hi unchanged.
- Start MULT; drive reset low asynchronously between edges at cycle 10 -> busy, hi and lo drop to 0 immediately, no done pulse. After release, new MULTU 6*7 -> lo=42.
